fpu_sub_seq: RTL

Multi-cycle IEEE-754 subtractor computing result = a − b. It is the inverse-direction companion to the combinational fpu_add.
- A start/done handshake and an explicit FSM break the datapath into registered stages.
- Normalization is serial, trading latency for area on long FP chains in the DSP pipeline.
- It uses the same `double` parameter and the same result/exception conventions as fpu_add, so the two are interchangeable at the datapath level.

---
 rtl/fpu_pkg.sv | 43 ++++
 rtl/fpu_round_rne.sv | 42 ++++
 rtl/fpu_sub_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: precision-dependent widths, FSM states,
// canonical special values and field-extract helpers for the fpu_* blocks.
package fpu_pkg;

    localparam logic [31:0] NAN_S = 32'h7fc0_0000;
    localparam logic [63:0] NAN_D = 64'h7ff8_0000_0000_0000;
    localparam logic [31:0] INF_S = 32'h7f80_0000;
    localparam logic [63:0] INF_D = 64'h7ff0_0000_0000_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_DONE
    } state_t;

    function automatic int fp_w(input bit dbl);
        return dbl ? 64 : 32;
    endfunction

    function automatic int fp_ew(input bit dbl);
        return dbl ? 11 : 8;
    endfunction

    function automatic int fp_mw(input bit dbl);
        return dbl ? 52 : 23;
    endfunction

    // Operands are passed zero-extended to 64 bits so one helper serves both precisions.
    function automatic logic fp_sign(input logic [63:0] x, input bit dbl);
        return dbl ? x[63] : x[31];
    endfunction

    function automatic logic [10:0] fp_exp(input logic [63:0] x, input bit dbl);
        return dbl ? x[62:52] : {3'b000, x[30:23]};
    endfunction

    function automatic logic [51:0] fp_mant(input logic [63:0] x, input bit dbl);
        return dbl ? x[51:0] : {29'd0, x[22:0]};
    endfunction

    function automatic logic [63:0] fp_nan(input bit dbl);
        return dbl ? NAN_D : {32'd0, NAN_S};
    endfunction

endpackage

// File: rtl/fpu_round_rne.sv
// Combinational round-to-nearest-even on a normalized mantissa with G/R/S bits;
// flags exponent overflow after any rounding carry.
module fpu_round_rne
    import fpu_pkg::*;
#(
    parameter  bit double = 1'b0,
    localparam int EW     = fp_ew(double),
    localparam int MW     = fp_mw(double)
) (
    input  logic [MW:0]   mant,
    input  logic          g,
    input  logic          r,
    input  logic          s,
    input  logic [EW:0]   exp_in,
    output logic [MW-1:0] mant_out,
    output logic [EW-1:0] exp_out,
    output logic          ovf
);

    localparam logic [EW:0] EXP_ONE = {{EW{1'b0}}, 1'b1};
    localparam logic [EW:0] EXP_MAX = {1'b0, {EW{1'b1}}};

    logic          up;
    logic [MW+1:0] sum;
    logic [EW:0]   exp_full;

    always_comb begin
        up  = g & (r | s | mant[0]);
        sum = {1'b0, mant} + {{(MW+1){1'b0}}, up};
        // A carry out of the hidden bit means the mantissa wrapped to 10..0.
        if (sum[MW+1]) begin
            mant_out = sum[MW:1];
            exp_full = exp_in + EXP_ONE;
        end else begin
            mant_out = sum[MW-1:0];
            exp_full = exp_in;
        end
        exp_out = exp_full[EW-1:0];
        ovf     = (exp_full >= EXP_MAX);
    end

endmodule

// File: rtl/fpu_sub_seq.sv
// Multi-cycle IEEE-754 subtractor (a - b) with start/done handshake and a
// serial one-bit-per-cycle normalizer.
module fpu_sub_seq
    import fpu_pkg::*;
#(
    parameter  bit double = 1'b0,
    localparam int W      = fp_w(double),
    localparam int EW     = fp_ew(double),
    localparam int MW     = fp_mw(double)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         exception
);

    // Working mantissa: carry | hidden | MW fraction | G | R | S
    localparam int          M       = MW + 5;
    localparam logic [EW:0] EXP_ONE = {{EW{1'b0}}, 1'b1};
    localparam logic [EW:0] SH_CAP  = (EW+1)'(MW + 3);

    state_t state, state_nx;

    logic [W-1:0]  a_r, b_r;
    logic          sgn_x, sgn_y;
    logic [EW:0]   exp_x, exp_y;
    logic [M-1:0]  man_x, man_y;
    logic [W-1:0]  res_pend;
    logic          exc_pend;
    logic          accept;

    logic          sa, sb;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] fa, fb;
    logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;

    logic          x_big;
    logic [EW:0]   diff, shamt;
    logic [M-1:0]  small_man, shifted, aligned;
    logic          lost;
    logic [M-1:0]  sum, man_l;

    logic [MW-1:0] r_mant;
    logic [EW-1:0] r_exp;
    logic          r_ovf;

    assign accept = start && (state == S_IDLE) && !busy;

    always_comb begin
        sa     = fp_sign(64'(a_r), double);
        sb     = fp_sign(64'(b_r), double);
        ea     = EW'(fp_exp(64'(a_r), double));
        eb     = EW'(fp_exp(64'(b_r), double));
        fa     = MW'(fp_mant(64'(a_r), double));
        fb     = MW'(fp_mant(64'(b_r), double));
        a_nan  = (&ea) && (|fa);
        b_nan  = (&eb) && (|fb);
        a_inf  = (&ea) && !(|fa);
        b_inf  = (&eb) && !(|fb);
        a_zero = ~|ea;
        b_zero = ~|eb;
        special = a_nan | b_nan | a_inf | b_inf | (a_zero & b_zero);
    end

    // Alignment: larger magnitude goes to x, smaller is shifted right with sticky.
    always_comb begin
        x_big     = {exp_x, man_x} >= {exp_y, man_y};
        diff      = x_big ? (exp_x - exp_y) : (exp_y - exp_x);
        shamt     = (diff > SH_CAP) ? SH_CAP : diff;
        small_man = x_big ? man_y : man_x;
        shifted   = small_man >> shamt;
        lost      = |(small_man & ~({M{1'b1}} << shamt));
        aligned   = {shifted[M-1:1], shifted[0] | lost};
        sum       = (sgn_x == sgn_y) ? (man_x + man_y) : (man_x - man_y);
        man_l     = man_x << 1;
    end

    fpu_round_rne #(.double(double)) u_round (
        .mant     (man_x[M-2:3]),
        .g        (man_x[2]),
        .r        (man_x[1]),
        .s        (man_x[0]),
        .exp_in   (exp_x),
        .mant_out (r_mant),
        .exp_out  (r_exp),
        .ovf      (r_ovf)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_UNPACK;
            S_UNPACK: state_nx = special ? S_DONE : S_ALIGN;
            S_ALIGN:  state_nx = S_ADDSUB;
            S_ADDSUB: state_nx = (sum == '0) ? S_DONE : S_NORM;
            S_NORM: begin
                if (man_x[M-1] || man_x[M-2])
                    state_nx = S_ROUND;
                else if (exp_x <= EXP_ONE)
                    state_nx = S_DONE;
                else if (man_l[M-2])
                    state_nx = S_ROUND;
            end
            S_ROUND:  state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            exception <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == S_DONE);
            if (state == S_DONE) begin
                result    <= res_pend;
                exception <= exc_pend;
            end
            if (done)
                busy <= 1'b0;
            else if (accept)
                busy <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (accept) begin
                a_r <= a;
                b_r <= {~b[W-1], b[W-2:0]};
            end
            S_UNPACK: begin
                sgn_x <= sa;
                sgn_y <= sb;
                exp_x <= {1'b0, ea};
                exp_y <= {1'b0, eb};
                man_x <= a_zero ? '0 : {2'b01, fa, 3'b000};
                man_y <= b_zero ? '0 : {2'b01, fb, 3'b000};
                exc_pend <= 1'b0;
                if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
                    res_pend <= W'(fp_nan(double));
                    exc_pend <= 1'b1;
                end else if (a_inf)
                    res_pend <= {sa, {EW{1'b1}}, {MW{1'b0}}};
                else if (b_inf)
                    res_pend <= {sb, {EW{1'b1}}, {MW{1'b0}}};
                else
                    res_pend <= {sa & sb, {(W-1){1'b0}}};
            end
            S_ALIGN: begin
                sgn_x <= x_big ? sgn_x : sgn_y;
                sgn_y <= x_big ? sgn_y : sgn_x;
                exp_x <= x_big ? exp_x : exp_y;
                man_x <= x_big ? man_x : man_y;
                man_y <= aligned;
            end
            S_ADDSUB: begin
                man_x    <= sum;
                res_pend <= '0;
                exc_pend <= 1'b0;
            end
            S_NORM: begin
                // Carry folds the dropped bit into sticky; otherwise shift left one step.
                if (man_x[M-1]) begin
                    man_x <= {1'b0, man_x[M-1:2], man_x[1] | man_x[0]};
                    exp_x <= exp_x + EXP_ONE;
                end else if (!man_x[M-2]) begin
                    if (exp_x <= EXP_ONE) begin
                        res_pend <= {sgn_x, {(W-1){1'b0}}};
                        exc_pend <= 1'b0;
                    end else begin
                        man_x <= man_l;
                        exp_x <= exp_x - EXP_ONE;
                    end
                end
            end
            S_ROUND: begin
                res_pend <= r_ovf ? {sgn_x, {EW{1'b1}}, {MW{1'b0}}}
                                  : {sgn_x, r_exp, r_mant};
                exc_pend <= r_ovf;
            end
            default: ;
        endcase
    end

endmodule
